wide_to_narrow_fifo: RTL and testbench

Parametrised successor to the fixed 128-to-32 width-converting FIFO that sits between the AES peripheral output and the ICAPE2 configuration port.
- Accepts IN_WIDTH-bit entries and buffers up to DEPTH of them.
- Emits each entry as RATIO = IN_WIDTH/OUT_WIDTH consecutive OUT_WIDTH-bit words.
- Adds flow control, status, flush, selectable word order and optional per-byte bit reversal (ICAP bit-swap).

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/fifo_ram.sv | 26 ++
 rtl/wide_to_narrow_fifo.sv | 126 ++++++++++++
 tb/tb_wide_to_narrow_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the wide-to-narrow FIFO: derived widths, slice placement and ICAP byte bit-swap.
// Widths are passed in explicitly, so one package serves every parameterisation.
package fifo_pkg;

    function automatic int ratio_of(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_w(input int ratio);
        return $clog2(ratio);
    endfunction

    // Bit offset of slice k inside an entry; order 0 emits the most-significant slice first.
    function automatic int slice_select(input int k, input int order, input int in_w, input int out_w);
        return (order == 0) ? in_w - (k + 1) * out_w : k * out_w;
    endfunction

    function automatic logic [7:0] byte_bitswap(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH simple dual-port storage: registered write, combinational read.
// No reset on the array; contents are only meaningful between the pointers.
module fifo_ram #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wide_to_narrow_fifo.sv
// Buffers DEPTH wide entries and emits each as RATIO narrow words, one per read_en cycle (1-cycle latency).
// Writes to a full FIFO are dropped (sticky overflow) unless the head entry frees on the same edge.
module wide_to_narrow_fifo
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH   = 128,
    parameter int OUT_WIDTH  = 32,
    parameter int DEPTH      = 4,
    parameter int WORD_ORDER = 0,
    parameter int BITSWAP    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_en,
    input  logic [IN_WIDTH-1:0]        data_in,
    output logic                       full,
    output logic                       overflow,
    input  logic                       flush,
    input  logic                       read_en,
    output logic [OUT_WIDTH-1:0]       data_out,
    output logic                       data_valid,
    output logic                       empty,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int RATIO = ratio_of(IN_WIDTH, OUT_WIDTH);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int IDX_W = idx_w(RATIO);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("IN_WIDTH must be a multiple of OUT_WIDTH with a ratio of at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (BITSWAP != 0 && (OUT_WIDTH % 8) != 0) begin : g_bad_swap
        $error("BITSWAP needs OUT_WIDTH to be a whole number of bytes");
    end

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     cnt;
    logic [IN_WIDTH-1:0]  head;
    logic [OUT_WIDTH-1:0] slice_w;
    logic [OUT_WIDTH-1:0] word_w;
    logic                 pop;
    logic                 pop_last;
    logic                 push;
    logic                 drop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    assign pop      = read_en && !empty;
    assign pop_last = pop && (idx == IDX_W'(RATIO - 1));
    assign push     = write_en && (!full || pop_last);
    assign drop     = write_en && full && !pop_last;

    fifo_ram #(
        .WIDTH (IN_WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push && !flush && !rst),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign slice_w = head[slice_select(int'(idx), WORD_ORDER, IN_WIDTH, OUT_WIDTH) +: OUT_WIDTH];

    if (BITSWAP != 0) begin : g_swap
        for (genvar j = 0; j < OUT_WIDTH / 8; j++) begin : g_byte
            assign word_w[8*j +: 8] = byte_bitswap(slice_w[8*j +: 8]);
        end
    end else begin : g_noswap
        assign word_w = slice_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            idx        <= '0;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (flush) begin
            // Overflow and the last emitted word survive a flush on purpose.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            idx        <= '0;
            cnt        <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= pop;
            if (pop) begin
                data_out <= word_w;
                if (pop_last) begin
                    idx    <= '0;
                    rd_ptr <= rd_ptr + 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push && !pop_last) begin
                cnt <= cnt + 1'b1;
            end else if (!push && pop_last) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wide_to_narrow_fifo.sv
// Drives three configurations (default, LS-slice first, bit-swapped) with one stimulus stream
// and compares each against a queue-based model every cycle, plus literal spot checks.
module tb_wide_to_narrow_fifo;

    localparam int NC = 3;
    localparam bit ORD [NC] = '{1'b0, 1'b1, 1'b0};
    localparam bit SWP [NC] = '{1'b0, 1'b0, 1'b1};

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           write_en = 1'b0;
    logic [127:0]   data_in = '0;
    logic           flush = 1'b0;
    logic           read_en = 1'b0;

    logic [NC-1:0]        full_o;
    logic [NC-1:0]        ovf_o;
    logic [NC-1:0]        dv_o;
    logic [NC-1:0]        empty_o;
    logic [NC-1:0][31:0]  dout_o;
    logic [NC-1:0][2:0]   cnt_o;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_on   = 1'b0;

    // Reference model state
    logic [127:0] mq [$];
    int           m_idx;
    logic [31:0]  m_dout [NC];
    bit           m_dv;
    bit           m_ovf;
    int           m_n;
    bit           m_last;

    always #5 clk = ~clk;

    wide_to_narrow_fifo #(.WORD_ORDER(0), .BITSWAP(0)) dut0 (
        .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .full(full_o[0]),
        .overflow(ovf_o[0]), .flush(flush), .read_en(read_en), .data_out(dout_o[0]),
        .data_valid(dv_o[0]), .empty(empty_o[0]), .count(cnt_o[0]));

    wide_to_narrow_fifo #(.WORD_ORDER(1), .BITSWAP(0)) dut1 (
        .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .full(full_o[1]),
        .overflow(ovf_o[1]), .flush(flush), .read_en(read_en), .data_out(dout_o[1]),
        .data_valid(dv_o[1]), .empty(empty_o[1]), .count(cnt_o[1]));

    wide_to_narrow_fifo #(.WORD_ORDER(0), .BITSWAP(1)) dut2 (
        .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .full(full_o[2]),
        .overflow(ovf_o[2]), .flush(flush), .read_en(read_en), .data_out(dout_o[2]),
        .data_valid(dv_o[2]), .empty(empty_o[2]), .count(cnt_o[2]));

    function automatic logic [31:0] exp_word(logic [127:0] e, int k, bit ord, bit sw);
        logic [127:0] sh;
        logic [31:0]  w;
        logic [31:0]  r;
        sh = ord ? (e >> (k * 32)) : (e >> ((3 - k) * 32));
        w  = sh[31:0];
        r  = w;
        if (sw) begin
            for (int j = 0; j < 4; j++) begin
                for (int b = 0; b < 8; b++) begin
                    r[8*j + b] = w[8*j + 7 - b];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] ent(int i);
        return {32'(i * 16), 32'(i * 16 + 1), 32'(i * 16 + 2), 32'(i * 16 + 3)};
    endfunction

    task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d at %0t: got %h, expected %h", nm, c, $time, act, exp);
        end
    endtask

    task automatic step(bit we, logic [127:0] din, bit re, bit fl, bit rs);
        write_en = we;
        data_in  = din;
        read_en  = re;
        flush    = fl;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    // Model advances on the same edge the DUTs sample; inputs are stable here.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_idx = 0;
            m_dv  = 1'b0;
            m_ovf = 1'b0;
            for (int c = 0; c < NC; c++) m_dout[c] = '0;
        end else if (flush) begin
            mq.delete();
            m_idx = 0;
            m_dv  = 1'b0;
        end else begin
            m_n    = mq.size();
            m_last = 1'b0;
            if (read_en && m_n > 0) begin
                for (int c = 0; c < NC; c++) m_dout[c] = exp_word(mq[0], m_idx, ORD[c], SWP[c]);
                m_dv = 1'b1;
                if (m_idx == 3) begin
                    m_last = 1'b1;
                    m_idx  = 0;
                    void'(mq.pop_front());
                end else begin
                    m_idx++;
                end
            end else begin
                m_dv = 1'b0;
            end
            if (write_en) begin
                if (m_n < 4 || m_last) mq.push_back(data_in);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int c = 0; c < NC; c++) begin
                chk("data_valid", c, 32'(dv_o[c]), 32'(m_dv));
                chk("data_out",   c, dout_o[c], m_dout[c]);
                chk("count",      c, 32'(cnt_o[c]), 32'(mq.size()));
                chk("full",       c, 32'(full_o[c]), 32'(mq.size() == 4));
                chk("empty",      c, 32'(empty_o[c]), 32'(mq.size() == 0));
                chk("overflow",   c, 32'(ovf_o[c]), 32'(m_ovf));
            end
        end
    end

    initial begin
        logic [127:0] e;
        logic [31:0]  la [4];
        logic [31:0]  lb [4];
        la = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        lb = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        e  = 128'h00112233_44556677_8899AABB_CCDDEEFF;

        step(0, '0, 0, 0, 1);
        chk_on = 1'b1;
        chk("lit reset empty", 0, 32'(empty_o[0]), 32'd1);
        chk("lit reset count", 0, 32'(cnt_o[0]), 32'd0);
        chk("lit reset full", 0, 32'(full_o[0]), 32'd0);
        chk("lit reset dout", 0, dout_o[0], 32'd0);

        // Word order, latency and bit-swap
        step(1, e, 1, 0, 0);
        chk("lit latency dv", 0, 32'(dv_o[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(0, '0, 1, 0, 0);
            chk("lit msb-first word", 0, dout_o[0], la[k]);
            chk("lit lsb-first word", 1, dout_o[1], lb[k]);
            chk("lit word dv", 0, 32'(dv_o[0]), 32'd1);
        end
        step(0, '0, 1, 0, 0);
        chk("lit drained dv", 0, 32'(dv_o[0]), 32'd0);
        chk("lit drained empty", 0, 32'(empty_o[0]), 32'd1);
        step(1, {32'h0180AA55, 96'h0}, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("lit bitswap word", 2, dout_o[2], 32'h800155AA);
        repeat (4) step(0, '0, 1, 0, 0);

        // Overfill with reads held off, then drain everything
        step(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, ent(i), 0, 0, 0);
            if (i == 3) chk("lit full after 4", 0, 32'(full_o[0]), 32'd1);
        end
        chk("lit overflow set", 0, 32'(ovf_o[0]), 32'd1);
        chk("lit count at full", 0, 32'(cnt_o[0]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                step(0, '0, 1, 0, 0);
                chk("lit drain order", 0, dout_o[0], 32'(i * 16 + k));
            end
        end
        chk("lit overflow kept", 0, 32'(ovf_o[0]), 32'd1);
        chk("lit drain empty", 0, 32'(empty_o[0]), 32'd1);

        // Push on the edge that frees the head of a full FIFO, then stutter reads
        step(0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, ent(i), 0, 0, 0);
        repeat (3) step(0, '0, 1, 0, 0);
        step(1, ent(9), 1, 0, 0);
        chk("lit lossless overflow", 0, 32'(ovf_o[0]), 32'd0);
        chk("lit lossless count", 0, 32'(cnt_o[0]), 32'd4);
        for (int i = 0; i < 24; i++) step(0, '0, (i % 3) != 0, 0, 0);
        repeat (20) step(0, '0, 1, 0, 0);

        // Reset and flush mid-entry
        step(1, ent(5), 0, 0, 0);
        repeat (2) step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 1);
        chk("lit rst dv", 0, 32'(dv_o[0]), 32'd0);
        chk("lit rst count", 0, 32'(cnt_o[0]), 32'd0);
        step(1, ent(6), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("lit after rst slice0", 0, dout_o[0], 32'(6 * 16));
        step(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, ent(i), 0, 0, 0);
        repeat (2) step(0, '0, 1, 0, 0);
        step(0, '0, 1, 1, 0);
        chk("lit flush dv", 0, 32'(dv_o[0]), 32'd0);
        chk("lit flush empty", 0, 32'(empty_o[0]), 32'd1);
        chk("lit flush keeps overflow", 0, 32'(ovf_o[0]), 32'd1);
        chk("lit flush keeps dout", 0, dout_o[0], 32'd1);
        step(1, ent(7), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("lit after flush slice0", 0, dout_o[0], 32'(7 * 16));
        step(0, '0, 0, 0, 1);
        chk("lit rst clears overflow", 0, 32'(ovf_o[0]), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 45,
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 199) < 1);
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
